// File: rtl/data_table_search_res_merger.sv
// Result merger for the parallel data-table search.
// Each engine feeds its own small FIFO. Results are re-emitted on a single
// ready/valid stream in round-robin dispatch order, which is engine 0, 1, ..
// ENGINES_CNT-1, then 0 again, whatever order the engines finish in.
module data_table_search_res_merger #(
  parameter int ENGINES_CNT = 3,
  parameter int RES_WIDTH   = 64,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  logic [ENGINES_CNT-1:0]             eng_valid_i,
  output logic [ENGINES_CNT-1:0]             eng_ready_o,
  input  logic [ENGINES_CNT*RES_WIDTH-1:0]   eng_data_i,
  output logic                               res_valid_o,
  input  logic                               res_ready_i,
  output logic [RES_WIDTH-1:0]               res_data_o,
  output logic [$clog2(ENGINES_CNT)-1:0]     res_eng_o,
  output logic [CNT_WIDTH-1:0]               res_cnt_o
);

  localparam int ENG_W = $clog2(ENGINES_CNT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [RES_WIDTH-1:0]   mem_r    [ENGINES_CNT][FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_idx_r [ENGINES_CNT];
  logic [PTR_W-1:0]       rd_idx_r [ENGINES_CNT];
  logic [OCC_W-1:0]       occ_r    [ENGINES_CNT];

  logic [ENGINES_CNT-1:0] full_s;
  logic [ENGINES_CNT-1:0] empty_s;
  logic [ENGINES_CNT-1:0] wr_en_s;
  logic [ENGINES_CNT-1:0] sel_s;
  logic [ENGINES_CNT-1:0] pop_s;
  logic [ENG_W-1:0]       rd_ptr_r;
  logic [ENG_W-1:0]       rd_ptr_nxt_s;
  logic [RES_WIDTH-1:0]   head_s;
  logic                   head_empty_s;
  logic                   load_s;

  // FIFO status comes from registered occupancy only, so a pop never
  // makes a full FIFO ready within the same cycle.
  always_comb begin
    for (int g = 0; g < ENGINES_CNT; g++) begin
      full_s[g]  = (occ_r[g] == OCC_W'(FIFO_DEPTH));
      empty_s[g] = (occ_r[g] == OCC_W'(0));
      wr_en_s[g] = eng_valid_i[g] & ~full_s[g];
    end
  end

  assign eng_ready_o = ~full_s;

  // Select the head of the FIFO named by the order pointer (AND-OR mux).
  always_comb begin
    head_s       = '0;
    head_empty_s = 1'b1;
    for (int g = 0; g < ENGINES_CNT; g++) begin
      sel_s[g]     = (rd_ptr_r == ENG_W'(g));
      head_s       = head_s | ({RES_WIDTH{sel_s[g]}} & mem_r[g][rd_idx_r[g]]);
      head_empty_s = head_empty_s & ~(sel_s[g] & ~empty_s[g]);
    end
  end

  // Load the output register whenever the in-order FIFO has data and the
  // output slot is free or being emptied this cycle; never skip an engine.
  always_comb begin
    load_s = ~head_empty_s & (~res_valid_o | res_ready_i);
    pop_s  = sel_s & {ENGINES_CNT{load_s}};
    if (rd_ptr_r == ENG_W'(ENGINES_CNT - 1)) begin
      rd_ptr_nxt_s = '0;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r + ENG_W'(1);
    end
  end

  // FIFO storage; contents are qualified by occupancy so no reset is needed.
  always_ff @(posedge clk_i) begin
    for (int g = 0; g < ENGINES_CNT; g++) begin
      if (wr_en_s[g]) begin
        mem_r[g][wr_idx_r[g]] <= eng_data_i[g*RES_WIDTH +: RES_WIDTH];
      end
    end
  end

  // FIFO pointers and occupancy; simultaneous write and pop leave occupancy unchanged.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int g = 0; g < ENGINES_CNT; g++) begin
        wr_idx_r[g] <= '0;
        rd_idx_r[g] <= '0;
        occ_r[g]    <= '0;
      end
    end else begin
      for (int g = 0; g < ENGINES_CNT; g++) begin
        if (wr_en_s[g]) begin
          wr_idx_r[g] <= wr_idx_r[g] + PTR_W'(1);
        end
        if (pop_s[g]) begin
          rd_idx_r[g] <= rd_idx_r[g] + PTR_W'(1);
        end
        occ_r[g] <= occ_r[g] + OCC_W'(wr_en_s[g]) - OCC_W'(pop_s[g]);
      end
    end
  end

  // Output register and order pointer; data holds while stalled.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      res_valid_o <= 1'b0;
      res_data_o  <= '0;
      res_eng_o   <= '0;
      rd_ptr_r    <= '0;
    end else if (load_s) begin
      res_valid_o <= 1'b1;
      res_data_o  <= head_s;
      res_eng_o   <= rd_ptr_r;
      rd_ptr_r    <= rd_ptr_nxt_s;
    end else if (res_valid_o & res_ready_i) begin
      res_valid_o <= 1'b0;
    end
  end

  // Delivered-results counter, wraps naturally at its width.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      res_cnt_o <= '0;
    end else if (res_valid_o & res_ready_i) begin
      res_cnt_o <= res_cnt_o + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_data_table_search_res_merger.sv
// Bench for data_table_search_res_merger: directed table scenarios with
// exact timing expectations, backpressure, mid-operation reset and a long
// random run, all checked against an in-order scoreboard.
module tb_data_table_search_res_merger;

  logic         clk;
  logic         rst_n;
  logic [2:0]   eng_valid;
  logic [2:0]   eng_ready;
  logic [191:0] eng_data;
  logic         res_valid;
  logic         res_ready;
  logic [63:0]  res_data;
  logic [1:0]   res_eng;
  logic [31:0]  res_cnt;

  data_table_search_res_merger #(
    .ENGINES_CNT(3), .RES_WIDTH(64), .FIFO_DEPTH(4), .CNT_WIDTH(32)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .eng_valid_i(eng_valid), .eng_ready_o(eng_ready), .eng_data_i(eng_data),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
    .res_eng_o(res_eng), .res_cnt_o(res_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          sc;
    int          t;
    int          eng;
    logic [63:0] data;
    int          exp_eng;
    logic [63:0] exp_data;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  eng;
  } exp_t;

  vec_t        vecs [15];
  int          sc_first [5];
  int          sc_last  [5];
  exp_t        exp_q [$];
  logic [63:0] pend_q [3][$];
  bit          eng_en [3];
  int          eng_pct;
  int          rdy_pct;
  int          next_eng;
  int          n_checks;
  int          n_fail;
  int          edges;
  int          first_valid;
  int          last_hs;
  int          hs_cnt;
  bit          hold_prev;
  logic [63:0] hold_data;
  logic [1:0]  hold_eng;
  logic [63:0] d0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic fail_now(string name, string act, string req);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %s required %s", name, act, req);
  endtask

  // Output-side observer, called at the falling edge inside step().
  task automatic monitor();
    exp_t e;
    if (res_valid && first_valid < 0) first_valid = edges;
    if (hold_prev) begin
      chk("hold_data", res_data, hold_data);
      chk("hold_eng", 64'(res_eng), 64'(hold_eng));
    end
    chk("res_cnt", 64'(res_cnt), 64'(hs_cnt));
    if (res_valid && res_ready) begin
      last_hs = edges;
      if (exp_q.size() == 0) begin
        fail_now("unexpected_result", $sformatf("%h", res_data), "no result");
      end else begin
        e = exp_q.pop_front();
        chk("res_data", res_data, e.data);
        chk("res_eng", 64'(res_eng), 64'(e.eng));
      end
      hs_cnt++;
    end
    hold_prev = res_valid && !res_ready;
    hold_data = res_data;
    hold_eng  = res_eng;
  endtask

  // One clock: observe at negedge, then update inputs 1ns after posedge.
  task automatic step(bit auto_drv);
    bit acc [3];
    @(negedge clk);
    monitor();
    for (int g = 0; g < 3; g++) acc[g] = eng_valid[g] && eng_ready[g];
    @(posedge clk);
    #1;
    edges++;
    for (int g = 0; g < 3; g++) begin
      if (!auto_drv) begin
        eng_valid[g] = 1'b0;
      end else begin
        if (acc[g]) void'(pend_q[g].pop_front());
        if (!(eng_valid[g] && !acc[g])) begin
          if (eng_en[g] && pend_q[g].size() > 0 && $urandom_range(99) < eng_pct) begin
            eng_valid[g] = 1'b1;
            eng_data[g*64 +: 64] = pend_q[g][0];
          end else begin
            eng_valid[g] = 1'b0;
            eng_data[g*64 +: 64] = {$urandom, $urandom};
          end
        end
      end
    end
    if (auto_drv) res_ready = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic dispatch(int n);
    logic [63:0] d;
    exp_t e;
    for (int k = 0; k < n; k++) begin
      d = {$urandom, $urandom};
      pend_q[next_eng].push_back(d);
      e.data = d;
      e.eng  = 2'(next_eng);
      exp_q.push_back(e);
      next_eng = (next_eng + 1) % 3;
    end
  endtask

  task automatic drain(int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step(1'b1);
      n++;
    end
    if (exp_q.size() > 0) begin
      fail_now("drain_timeout", $sformatf("%0d left", exp_q.size()), "0 left");
      exp_q.delete();
    end
  endtask

  task automatic run_sc(int sc);
    int   base;
    int   maxt;
    exp_t e;
    base = edges;
    first_valid = -1;
    last_hs = -1;
    maxt = 0;
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].sc == sc) begin
        e.data = vecs[i].exp_data;
        e.eng  = 2'(vecs[i].exp_eng);
        exp_q.push_back(e);
        if (vecs[i].t > maxt) maxt = vecs[i].t;
      end
    end
    for (int c = 0; c <= maxt + 30; c++) begin
      if (c > maxt && exp_q.size() == 0) break;
      for (int i = 0; i < 15; i++) begin
        if (vecs[i].sc == sc && vecs[i].t == c) begin
          eng_valid[vecs[i].eng] = 1'b1;
          eng_data[vecs[i].eng*64 +: 64] = vecs[i].data;
        end
      end
      step(1'b0);
    end
    if (exp_q.size() > 0) begin
      fail_now($sformatf("drain_sc%0d", sc), $sformatf("%0d left", exp_q.size()), "0 left");
      exp_q.delete();
    end
    chk($sformatf("first_valid_sc%0d", sc), 64'(first_valid - base), 64'(sc_first[sc]));
    chk($sformatf("last_handshake_sc%0d", sc), 64'(last_hs - base), 64'(sc_last[sc]));
  endtask

  initial begin
    // sc1 in order, sc2 out of order, sc3 wrap of 7, sc4 proves pointer at engine 1
    vecs[0]  = '{1, 0, 0, 64'hAAAA_0000_0000_0001, 0, 64'hAAAA_0000_0000_0001};
    vecs[1]  = '{1, 1, 1, 64'hBBBB_0000_0000_0002, 1, 64'hBBBB_0000_0000_0002};
    vecs[2]  = '{1, 2, 2, 64'hCCCC_0000_0000_0003, 2, 64'hCCCC_0000_0000_0003};
    vecs[3]  = '{2, 5, 0, 64'hAAAA_1111_0000_0004, 0, 64'hAAAA_1111_0000_0004};
    vecs[4]  = '{2, 1, 1, 64'hBBBB_1111_0000_0005, 1, 64'hBBBB_1111_0000_0005};
    vecs[5]  = '{2, 0, 2, 64'hCCCC_1111_0000_0006, 2, 64'hCCCC_1111_0000_0006};
    vecs[6]  = '{3, 0, 0, 64'h0000_2222_0000_0010, 0, 64'h0000_2222_0000_0010};
    vecs[7]  = '{3, 0, 1, 64'h0000_2222_0000_0011, 1, 64'h0000_2222_0000_0011};
    vecs[8]  = '{3, 0, 2, 64'h0000_2222_0000_0012, 2, 64'h0000_2222_0000_0012};
    vecs[9]  = '{3, 1, 0, 64'h0000_2222_0000_0013, 0, 64'h0000_2222_0000_0013};
    vecs[10] = '{3, 1, 1, 64'h0000_2222_0000_0014, 1, 64'h0000_2222_0000_0014};
    vecs[11] = '{3, 1, 2, 64'h0000_2222_0000_0015, 2, 64'h0000_2222_0000_0015};
    vecs[12] = '{3, 2, 0, 64'h0000_2222_0000_0016, 0, 64'h0000_2222_0000_0016};
    vecs[13] = '{4, 0, 1, 64'h0000_3333_0000_0020, 1, 64'h0000_3333_0000_0020};
    vecs[14] = '{4, 0, 2, 64'h0000_3333_0000_0021, 2, 64'h0000_3333_0000_0021};
    sc_first = '{0, 2, 7, 2, 2};
    sc_last  = '{0, 4, 9, 8, 3};

    n_checks = 0; n_fail = 0; edges = 0; hs_cnt = 0; hold_prev = 1'b0;
    next_eng = 0; eng_pct = 100; rdy_pct = 100;
    eng_en = '{1'b1, 1'b1, 1'b1};
    rst_n = 1'b0; eng_valid = 3'b000; eng_data = '0; res_ready = 1'b1;

    // reset values
    #2;
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_data", res_data, 64'd0);
    chk("rst_eng", 64'(res_eng), 64'd0);
    chk("rst_cnt", 64'(res_cnt), 64'd0);
    chk("rst_eng_ready", 64'(eng_ready), 64'd7);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // table-driven directed scenarios
    run_sc(1);
    chk("cnt_after_in_order", 64'(res_cnt), 64'd3);
    run_sc(2);
    run_sc(3);
    run_sc(4);
    chk("cnt_after_tables", 64'(res_cnt), 64'd15);

    // backpressure: only engine 0 returns while the consumer stalls
    rdy_pct = 0; res_ready = 1'b0; eng_pct = 100;
    eng_en = '{1'b1, 1'b0, 1'b0};
    dispatch(18);
    d0 = exp_q[0].data;
    repeat (12) step(1'b1);
    chk("bp_eng_ready0", 64'(eng_ready[0]), 64'd0);
    chk("bp_eng0_accepted", 64'(pend_q[0].size()), 64'd1);
    chk("bp_valid", 64'(res_valid), 64'd1);
    chk("bp_held_data", res_data, d0);
    eng_en = '{1'b1, 1'b1, 1'b1};
    rdy_pct = 100;
    drain(200);
    chk("bp_eng_ready_after", 64'(eng_ready), 64'd7);
    chk("bp_valid_after", 64'(res_valid), 64'd0);

    // reset mid-operation with one result held and two queued
    rdy_pct = 0; res_ready = 1'b0;
    dispatch(3);
    repeat (6) step(1'b1);
    chk("pre_rst_valid", 64'(res_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(res_valid), 64'd0);
    chk("mid_rst_cnt", 64'(res_cnt), 64'd0);
    chk("mid_rst_eng_ready", 64'(eng_ready), 64'd7);
    chk("mid_rst_data", res_data, 64'd0);
    exp_q.delete();
    for (int g = 0; g < 3; g++) pend_q[g].delete();
    next_eng = 0; hs_cnt = 0; hold_prev = 1'b0;
    eng_valid = 3'b000; res_ready = 1'b1; rdy_pct = 100;
    #3;
    rst_n = 1'b1;
    dispatch(3);
    drain(50);
    chk("cnt_after_reset", 64'(res_cnt), 64'd3);

    // long random run
    eng_pct = 30; rdy_pct = 70;
    dispatch(10000);
    drain(60000);
    repeat (2) step(1'b1);
    chk("cnt_final", 64'(res_cnt), 64'd10003);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
